// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the elastic pipeline register chain.
// Each stage's per-cycle action is decoded once here so every stage instance uses the same priority.
package pipe_reg_chain_pkg;

    typedef enum logic [1:0] {
        STG_HOLD,
        STG_BUBBLE,
        STG_LOAD,
        STG_CLEAR
    } stage_op_e;

    // Squash wins over everything. A stage that advances takes a bubble without touching its data.
    function automatic stage_op_e stage_op(input logic clr, input logic load, input logic up_valid);
        if (clr)
            return STG_CLEAR;
        if (!load)
            return STG_HOLD;
        return up_valid ? STG_LOAD : STG_BUBBLE;
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One {valid, data} register with load enable, asynchronous active-low reset and synchronous clear.
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    stage_op_e op;

    always_comb op = stage_op(clr, load, up_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            case (op)
                STG_CLEAR:  valid <= 1'b0;
                STG_BUBBLE: valid <= 1'b0;
                STG_LOAD: begin
                    valid <= 1'b1;
                    data  <= up_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapse, flush and occupancy count.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned  WIDTH = 32,
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("pipe_reg_chain: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];

    // Ready ripples tail to head: a stage may advance if any stage downstream is empty or the sink pops.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            chain             = chain | ~v[DEPTH-1-k];
            adv[DEPTH-1-k]    = chain;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_link
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .clr      (flush),
            .load     (adv[i]),
            .up_valid (up_v),
            .up_data  (up_d),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    always_comb begin
        count = '0;
        for (int unsigned k = 0; k < DEPTH; k++)
            count = count + CNT_W'(v[k]);
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed DEPTH=2 scenarios plus randomized runs at DEPTH 1, 3 and 4.
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    always #5 clk = ~clk;

    logic        ir1, ir2, ir3, ir4;
    logic        ov1, ov2, ov3, ov4;
    logic [31:0] od1, od2, od3, od4;
    logic [0:0]  c1;
    logic [1:0]  c2, c3;
    logic [2:0]  c4;

    pipe_reg_chain #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .count(c1));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(c2));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .count(c3));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .count(c4));

    int          sel;
    logic        o_ir, o_ov;
    logic [31:0] o_od;
    logic [2:0]  o_cnt;

    always_comb begin
        o_ir = ir2; o_ov = ov2; o_od = od2; o_cnt = {1'b0, c2};
        case (sel)
            0: begin o_ir = ir1; o_ov = ov1; o_od = od1; o_cnt = {2'b0, c1}; end
            2: begin o_ir = ir3; o_ov = ov3; o_od = od3; o_cnt = {1'b0, c3}; end
            3: begin o_ir = ir4; o_ov = ov4; o_od = od4; o_cnt = c4; end
            default: ;
        endcase
    end

    // Reference model: beats in arrival order, each tagged with the stage it occupies.
    typedef struct {
        logic [31:0] data;
        int          pos;
    } beat_t;

    beat_t       mq[$];
    logic [31:0] out_log[$];
    int          depth;
    int          cyc, first_acc, first_out;
    int          total, bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic m_out_valid();
        return (mq.size() > 0) && (mq[0].pos == depth - 1);
    endfunction

    function automatic logic m_in_ready();
        return !flush && (out_ready || mq.size() < depth);
    endfunction

    // A beat moves forward when the sink pops or some stage ahead of it is empty;
    // with k older beats ahead, a free slot exists iff k < depth-1-pos.
    task automatic model_step();
        logic pop, acc;
        if (!reset) begin
            mq.delete();
            return;
        end
        pop = m_out_valid() && out_ready;
        acc = in_valid && m_in_ready();
        if (flush) begin
            mq.delete();
            return;
        end
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].pos != depth - 1 && (out_ready || k < depth - 1 - mq[k].pos))
                mq[k].pos++;
        end
        if (pop)
            void'(mq.pop_front());
        if (acc)
            mq.push_back('{in_data, 0});
    endtask

    task automatic cycle();
        #1;
        check("in_ready", {63'b0, o_ir}, {63'b0, m_in_ready()});
        check("out_valid", {63'b0, o_ov}, {63'b0, m_out_valid()});
        if (m_out_valid())
            check("out_data", {32'b0, o_od}, {32'b0, mq[0].data});
        check("count", {61'b0, o_cnt}, 64'(mq.size()));
        if (o_ov && out_ready && reset)
            out_log.push_back(o_od);
        if (o_ov && first_out < 0)
            first_out = cyc;
        if (in_valid && o_ir && reset && first_acc < 0)
            first_acc = cyc;
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_bp [3];
        total = 0; bad = 0; cyc = 0; first_acc = -1; first_out = -1;
        sel = 1; depth = 2;

        // Reset held with a live input beat
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        #1;
        check("rst_out_valid", {63'b0, o_ov}, 64'd0);
        check("rst_out_data", {32'b0, o_od}, 64'd0);
        check("rst_count", {61'b0, o_cnt}, 64'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        cycle();
        check("post_rst_count", {61'b0, o_cnt}, 64'd0);

        // Streaming 1..10 at full rate
        out_log.delete(); first_acc = -1; first_out = -1;
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            #1 check("stream_in_ready", {63'b0, o_ir}, 64'd1);
            cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        check("stream_len", 64'(out_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < out_log.size(); i++)
            check("stream_order", {32'b0, out_log[i]}, 64'(i + 1));
        check("stream_latency", 64'(first_out - first_acc), 64'd2);

        // Back-pressure: A and B fill the chain, C waits upstream
        out_log.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA; cycle();
        in_data = 32'hB; cycle();
        in_data = 32'hC;
        #1;
        check("bp_count", {61'b0, o_cnt}, 64'd2);
        check("bp_in_ready", {63'b0, o_ir}, 64'd0);
        repeat (2) cycle();
        out_ready = 1'b1;
        #1 check("bp_release_ready", {63'b0, o_ir}, 64'd1);
        cycle();
        in_valid = 1'b0;
        repeat (4) cycle();
        exp_bp[0] = 32'hA; exp_bp[1] = 32'hB; exp_bp[2] = 32'hC;
        check("bp_len", 64'(out_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < out_log.size(); i++)
            check("bp_order", {32'b0, out_log[i]}, {32'b0, exp_bp[i]});

        // Full chain with simultaneous push and pop
        out_log.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'd1; cycle();
        in_data = 32'd2; cycle();
        out_ready = 1'b1; in_data = 32'd3;
        #1;
        check("full_in_ready", {63'b0, o_ir}, 64'd1);
        check("full_out_valid", {63'b0, o_ov}, 64'd1);
        cycle();
        check("full_count_kept", {61'b0, o_cnt}, 64'd2);
        check("full_one_out", 64'(out_log.size()), 64'd1);
        in_valid = 1'b0;
        repeat (3) cycle();
        check("full_len", 64'(out_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < out_log.size(); i++)
            check("full_order", {32'b0, out_log[i]}, 64'(i + 1));

        // Flush discards the held beats and the incoming 0x55
        out_log.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h11; cycle();
        in_data = 32'h22; cycle();
        flush = 1'b1; in_data = 32'h55;
        #1 check("flush_in_ready", {63'b0, o_ir}, 64'd0);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_count", {61'b0, o_cnt}, 64'd0);
        check("flush_out_valid", {63'b0, o_ov}, 64'd0);
        out_ready = 1'b1;
        repeat (4) cycle();
        check("flush_no_leak", 64'(out_log.size()), 64'd0);

        // Randomized traffic at the other depths, with one asynchronous reset mid-stream
        for (int t = 0; t < 3; t++) begin
            sel   = (t == 0) ? 0 : t + 1;
            depth = sel + 1;
            reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            mq.delete();
            cycle();
            reset = 1'b1;
            for (int n = 0; n < 400; n++) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                flush     = ($urandom_range(0, 19) == 0);
                in_data   = $urandom;
                if (n == 200) begin
                    reset = 1'b0;
                    mq.delete();
                    #1;
                    check("async_rst_valid", {63'b0, o_ov}, 64'd0);
                    check("async_rst_count", {61'b0, o_cnt}, 64'd0);
                end
                cycle();
                if (n == 200)
                    reset = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
